frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Animation frame sequencer: vsync-driven frame counter with speed divisor, pause and single-step.
// Optional feature macro: FRAME_SEQ_STEP_EN enables the step input (otherwise step is ignored).
module frame_sequencer #(
    parameter logic [11:0] RESET_FRAME = 12'd300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        pause,
    input  logic        step,
    input  logic [1:0]  speed,
    output logic [11:0] frame_counter,
    output logic        frame_tick,
    output logic [1:0]  scene,
    output logic        scene_start,
    output logic [6:0]  phase
);

    typedef enum logic [1:0] {RUN, PAUSED, STEP_ARMED} state_e;

    state_e      state_q, state_d;
    logic        vsync_d_q;
    logic        pause_s1_q, pause_s2_q;
    logic [2:0]  presc_q, presc_d;
    logic [11:0] frame_q, frame_d;
    logic        tick_q, scene_start_q;
    logic        vs_edge, step_edge, advance;
    logic [2:0]  div_m1;

    assign vs_edge = vsync & ~vsync_d_q;
    assign frame_d = frame_q + 12'd1;

`ifdef FRAME_SEQ_STEP_EN
    logic step_s1_q, step_s2_q, step_s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
        end else begin
            step_s1_q <= step;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
        end
    end

    assign step_edge = step_s2_q & ~step_s3_q;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_edge   = 1'b0;
`endif

    always_comb begin
        div_m1 = 3'd0;
        case (speed)
            2'd0: div_m1 = 3'd0;
            2'd1: div_m1 = 3'd1;
            2'd2: div_m1 = 3'd3;
            2'd3: div_m1 = 3'd7;
            default: div_m1 = 3'd0;
        endcase
    end

    // A speed change can leave the prescaler above the new limit; >= advances on the next edge.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        advance = 1'b0;
        case (state_q)
            RUN: begin
                if (pause_s2_q) begin
                    state_d = PAUSED;
                end else if (vs_edge) begin
                    if (presc_q >= div_m1) begin
                        advance = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 3'd1;
                    end
                end
            end
            PAUSED: begin
                if (!pause_s2_q) begin
                    state_d = RUN;
                end else if (step_edge) begin
                    state_d = STEP_ARMED;
                end
            end
            STEP_ARMED: begin
                if (vs_edge) begin
                    advance = 1'b1;
                    presc_d = '0;
                    state_d = pause_s2_q ? PAUSED : RUN;
                end else if (!pause_s2_q) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            vsync_d_q     <= 1'b1;
            pause_s1_q    <= 1'b0;
            pause_s2_q    <= 1'b0;
            presc_q       <= '0;
            frame_q       <= RESET_FRAME;
            tick_q        <= 1'b0;
            scene_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_d_q     <= vsync;
            pause_s1_q    <= pause;
            pause_s2_q    <= pause_s1_q;
            presc_q       <= presc_d;
            tick_q        <= advance;
            scene_start_q <= advance && (frame_d[8:7] != frame_q[8:7]);
            if (advance) begin
                frame_q <= frame_d;
            end
        end
    end

    assign frame_counter = frame_q;
    assign frame_tick    = tick_q;
    assign scene         = frame_q[8:7];
    assign scene_start   = scene_start_q;
    assign phase         = frame_q[6:0];

endmodule
